uart_tx_sched: RTL and testbench

Schedules a single UART transmit line among NUM_REQ byte requesters. It arbitrates round-robin and latches the granted byte. It then sequences the frame on tx: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits, each bit timed by an internal baud counter. It sits between on-chip byte producers and the uart serial pin, replacing ad-hoc frame generation.

---
 rtl/uart_tx_sched.sv | 177 +++++++++++++++++
 tb/tb_uart_tx_sched.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler for one UART transmit line: grants one byte requester at a time
// and serialises its byte as start, 8 data bits LSB first, optional parity, 1-2 stop bits.
module uart_tx_sched #(
    parameter int NUM_REQ      = 2,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 2,
    localparam int ID_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] data,
    output logic [NUM_REQ-1:0]   gnt,
    output logic                 tx,
    output logic                 busy,
    output logic                 done,
    output logic [ID_W-1:0]      done_id
);
    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    if (NUM_REQ < 1 || NUM_REQ > 8 || CLKS_PER_BIT < 2 ||
        PARITY_EN < 0 || PARITY_EN > 1 || PARITY_ODD < 0 || PARITY_ODD > 1 ||
        (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_param_err
        $error("uart_tx_sched: illegal parameter value");
    end

    logic [2:0]         state;
    logic [CNT_W-1:0]   baud_cnt;
    logic [2:0]         bit_cnt;
    logic [7:0]         shreg;
    logic               parity_bit;
    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    cur_id;
    logic [ID_W-1:0]    arb_idx;
    logic [ID_W-1:0]    next_ptr;
    logic [ID_W-1:0]    lo_idx;
    logic [ID_W-1:0]    hi_idx;
    logic               lo_any;
    logic               hi_any;
    logic               arb_found;
    logic               arb_en;
    logic               baud_last;
    logic               stop_last;
    logic [NUM_REQ-1:0] arb_onehot;
    logic [7:0]         sel_byte;

    // Lowest requester at or above the pointer wins; otherwise wrap to the lowest overall.
    always_comb begin
        lo_any = 1'b0;
        hi_any = 1'b0;
        lo_idx = '0;
        hi_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                lo_any = 1'b1;
                lo_idx = ID_W'(i);
            end
            if (req[i] && i >= int'(rr_ptr)) begin
                hi_any = 1'b1;
                hi_idx = ID_W'(i);
            end
        end
        arb_found = lo_any;
        arb_idx   = hi_any ? hi_idx : lo_idx;
        arb_onehot = '0;
        arb_onehot[arb_idx] = 1'b1;
        next_ptr = (int'(arb_idx) == NUM_REQ - 1) ? '0 : arb_idx + ID_W'(1);
    end

    assign sel_byte  = data[{cur_id, 3'b000} +: 8];
    assign baud_last = (baud_cnt == CNT_W'(CLKS_PER_BIT - 1));
    assign stop_last = (state == S_STOP) && baud_last && (bit_cnt == 3'(STOP_BITS - 1));
    // Arbitration is also live on the last stop-bit cycle so a waiting requester is granted on the done cycle.
    assign arb_en    = arb_found && (((state == S_IDLE) && !(|gnt)) || stop_last);
    assign busy      = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            gnt        <= '0;
            tx         <= 1'b1;
            done       <= 1'b0;
            done_id    <= '0;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            parity_bit <= 1'b0;
            rr_ptr     <= '0;
            cur_id     <= '0;
        end else begin
            gnt  <= '0;
            done <= 1'b0;
            // NOTE: non-blocking updates let done_id capture the finishing cur_id on the same edge a new grant overwrites it.
            if (arb_en) begin
                gnt    <= arb_onehot;
                cur_id <= arb_idx;
                rr_ptr <= next_ptr;
            end
            case (state)
                S_IDLE: begin
                    tx <= 1'b1;
                    if (|gnt) begin
                        state      <= S_START;
                        tx         <= 1'b0;
                        baud_cnt   <= '0;
                        shreg      <= sel_byte;
                        parity_bit <= (^sel_byte) ^ 1'(PARITY_ODD);
                    end
                end
                S_START: begin
                    if (baud_last) begin
                        state    <= S_DATA;
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        tx       <= shreg[0];
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        bit_cnt  <= bit_cnt + 3'd1;
                        shreg    <= shreg >> 1;
                        if (bit_cnt == 3'd7) begin
                            if (PARITY_EN != 0) begin
                                state <= S_PARITY;
                                tx    <= parity_bit;
                            end else begin
                                state <= S_STOP;
                                tx    <= 1'b1;
                            end
                        end else begin
                            tx <= shreg[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                S_PARITY: begin
                    if (baud_last) begin
                        state    <= S_STOP;
                        baud_cnt <= '0;
                        tx       <= 1'b1;
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                S_STOP: begin
                    tx <= 1'b1;
                    if (baud_last) begin
                        baud_cnt <= '0;
                        if (stop_last) begin
                            state   <= S_IDLE;
                            bit_cnt <= '0;
                            done    <= 1'b1;
                            done_id <= cur_id;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_sched.sv
// Testbench for uart_tx_sched: three instances (default, odd parity, no parity + 1 stop)
// checked cycle by cycle against a frame-level model of the serial line.
module tb_uart_tx_sched;
    localparam int C = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] req_v     [3];
    logic [15:0] data_v   [3];
    logic [1:0] gnt_v     [3];
    logic       tx_v      [3];
    logic       busy_v    [3];
    logic       done_v    [3];
    logic [0:0] done_id_v [3];

    int compared   = 0;
    int mismatched = 0;
    int rr_model   = 0;

    always #5 clk = ~clk;

    uart_tx_sched dut0 (
        .clk(clk), .rst(rst), .req(req_v[0]), .data(data_v[0]), .gnt(gnt_v[0]),
        .tx(tx_v[0]), .busy(busy_v[0]), .done(done_v[0]), .done_id(done_id_v[0])
    );
    uart_tx_sched #(.PARITY_ODD(1)) dut_odd (
        .clk(clk), .rst(rst), .req(req_v[1]), .data(data_v[1]), .gnt(gnt_v[1]),
        .tx(tx_v[1]), .busy(busy_v[1]), .done(done_v[1]), .done_id(done_id_v[1])
    );
    uart_tx_sched #(.PARITY_EN(0), .STOP_BITS(1)) dut_np (
        .clk(clk), .rst(rst), .req(req_v[2]), .data(data_v[2]), .gnt(gnt_v[2]),
        .tx(tx_v[2]), .busy(busy_v[2]), .done(done_v[2]), .done_id(done_id_v[2])
    );

    function automatic int pen_of(input int w);   return (w == 2) ? 0 : 1; endfunction
    function automatic int podd_of(input int w);  return (w == 1) ? 1 : 0; endfunction
    function automatic int nstop_of(input int w); return (w == 2) ? 1 : 2; endfunction

    // Line level of each bit period in transmit order, index 0 = start bit.
    function automatic void build_frame(input int w, input logic [7:0] b,
                                        output int nbits, output logic [11:0] bits);
        int parity;
        bits  = '1;
        nbits = 0;
        bits[nbits] = 1'b0;
        nbits++;
        parity = podd_of(w);
        for (int i = 0; i < 8; i++) begin
            bits[nbits] = b[i];
            nbits++;
            if (b[i]) parity = 1 - parity;
        end
        if (pen_of(w) != 0) begin
            bits[nbits] = 1'(parity);
            nbits++;
        end
        nbits += nstop_of(w);
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        for (int w = 0; w < 3; w++) req_v[w] = 2'b00;
        repeat (2) @(negedge clk);
        for (int w = 0; w < 3; w++) begin
            compared++;
            if ({tx_v[w], gnt_v[w], busy_v[w], done_v[w], done_id_v[w]} !== 6'b1_00_0_0_0) begin
                mismatched++;
                $display("FAIL reset inst%0d: tx=%b gnt=%b busy=%b done=%b done_id=%b want 1 00 0 0 0",
                         w, tx_v[w], gnt_v[w], busy_v[w], done_v[w], done_id_v[w]);
            end
        end
        rst = 1'b0;
        rr_model = 0;
    endtask

    task automatic wait_gnt(input int w, input logic [1:0] exp, input string name, output int waited);
        waited = 0;
        while (gnt_v[w] === 2'b00 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        compared++;
        if (gnt_v[w] !== exp) begin
            mismatched++;
            $display("FAIL %s gnt: got %b want %b after %0d cycles", name, gnt_v[w], exp, waited);
        end
        compared++;
        if (busy_v[w] !== 1'b0 || tx_v[w] !== 1'b1) begin
            mismatched++;
            $display("FAIL %s gnt cycle line: busy=%b tx=%b want busy=0 tx=1", name, busy_v[w], tx_v[w]);
        end
    endtask

    // Called in the grant cycle; returns in the done cycle.
    task automatic run_frame(input int w, input logic [7:0] b, input int id, input string name);
        int         nbits;
        logic [11:0] bits;
        logic       exp_bit;
        build_frame(w, b, nbits, bits);
        for (int t = 1; t <= nbits * C; t++) begin
            @(negedge clk);
            exp_bit = bits[(t - 1) / C];
            compared++;
            if (tx_v[w] !== exp_bit) begin
                mismatched++;
                $display("FAIL %s tx at G+%0d: got %b want %b", name, t, tx_v[w], exp_bit);
            end
            compared++;
            if (busy_v[w] !== 1'b1 || done_v[w] !== 1'b0 || gnt_v[w] !== 2'b00) begin
                mismatched++;
                $display("FAIL %s status at G+%0d: busy=%b done=%b gnt=%b want 1 0 00",
                         name, t, busy_v[w], done_v[w], gnt_v[w]);
            end
        end
        @(negedge clk);
        compared++;
        if ({done_v[w], done_id_v[w], busy_v[w], tx_v[w]} !== {1'b1, 1'(id), 1'b0, 1'b1}) begin
            mismatched++;
            $display("FAIL %s done at G+%0d: done=%b done_id=%b busy=%b tx=%b want 1 %0d 0 1",
                     name, nbits * C + 1, done_v[w], done_id_v[w], busy_v[w], tx_v[w], id);
        end
    endtask

    task automatic check_quiet(input int w, input int n, input string name);
        for (int t = 0; t < n; t++) begin
            @(negedge clk);
            compared++;
            if (gnt_v[w] !== 2'b00 || tx_v[w] !== 1'b1 || done_v[w] !== 1'b0) begin
                mismatched++;
                $display("FAIL %s idle: gnt=%b tx=%b done=%b want 00 1 0", name, gnt_v[w], tx_v[w], done_v[w]);
            end
        end
    endtask

    task automatic test_reset();
        for (int w = 0; w < 3; w++) data_v[w] = 16'h0000;
        do_reset();
        check_quiet(0, 3, "reset quiet");
    endtask

    task automatic test_single();
        int waited;
        do_reset();
        data_v[0] = 16'h00A5;
        req_v[0]  = 2'b01;
        wait_gnt(0, 2'b01, "single", waited);
        compared++;
        if (waited != 1) begin
            mismatched++;
            $display("FAIL single gnt latency: got %0d want 1", waited);
        end
        req_v[0] = 2'b00;
        run_frame(0, 8'hA5, 0, "single");
    endtask

    task automatic test_alternate();
        int waited;
        do_reset();
        data_v[0] = 16'hFF00;
        req_v[0]  = 2'b11;
        wait_gnt(0, 2'b01, "alt g0", waited);
        run_frame(0, 8'h00, 0, "alt f0");
        wait_gnt(0, 2'b10, "alt g1", waited);
        compared++;
        if (waited != 0) begin
            mismatched++;
            $display("FAIL alt g1 not in done cycle: waited %0d want 0", waited);
        end
        run_frame(0, 8'hFF, 1, "alt f1");
        wait_gnt(0, 2'b01, "alt g2", waited);
        compared++;
        if (waited != 0) begin
            mismatched++;
            $display("FAIL alt g2 not in done cycle: waited %0d want 0", waited);
        end
        req_v[0] = 2'b00;
        run_frame(0, 8'h00, 0, "alt f2");
    endtask

    task automatic test_odd_parity();
        int waited;
        logic [7:0] bytes [2];
        bytes[0] = 8'h00;
        bytes[1] = 8'h01;
        for (int k = 0; k < 2; k++) begin
            data_v[1] = {8'h00, bytes[k]};
            req_v[1]  = 2'b01;
            wait_gnt(1, 2'b01, "odd", waited);
            req_v[1] = 2'b00;
            run_frame(1, bytes[k], 0, "odd");
        end
    endtask

    task automatic test_no_parity();
        int waited;
        data_v[2] = 16'h003C;
        req_v[2]  = 2'b01;
        wait_gnt(2, 2'b01, "nopar", waited);
        req_v[2] = 2'b00;
        run_frame(2, 8'h3C, 0, "nopar");
        check_quiet(2, 2, "nopar");
    endtask

    task automatic test_reset_midframe();
        int waited;
        do_reset();
        data_v[0] = 16'h0000;
        req_v[0]  = 2'b10;
        wait_gnt(0, 2'b10, "midrst", waited);
        req_v[0] = 2'b00;
        repeat (20) @(negedge clk);
        compared++;
        if (tx_v[0] !== 1'b0 || busy_v[0] !== 1'b1) begin
            mismatched++;
            $display("FAIL midrst before reset: tx=%b busy=%b want 0 1", tx_v[0], busy_v[0]);
        end
        rst = 1'b1;
        @(negedge clk);
        compared++;
        if (tx_v[0] !== 1'b1 || busy_v[0] !== 1'b0 || done_v[0] !== 1'b0) begin
            mismatched++;
            $display("FAIL midrst after reset: tx=%b busy=%b done=%b want 1 0 0", tx_v[0], busy_v[0], done_v[0]);
        end
        rst       = 1'b0;
        data_v[0] = 16'h003C;
        req_v[0]  = 2'b11;
        wait_gnt(0, 2'b01, "midrst regrant", waited);
        compared++;
        if (done_v[0] !== 1'b0) begin
            mismatched++;
            $display("FAIL midrst spurious done: got %b want 0", done_v[0]);
        end
        req_v[0] = 2'b00;
        run_frame(0, 8'h3C, 0, "midrst frame");
    endtask

    task automatic test_withdraw_sample();
        int waited;
        data_v[0] = 16'h00C3;
        req_v[0]  = 2'b01;
        wait_gnt(0, 2'b01, "withdraw", waited);
        req_v[0] = 2'b00;
        fork
            run_frame(0, 8'hC3, 0, "withdraw");
            begin
                @(negedge clk);
                data_v[0][7:0] = 8'h3C;
                repeat (2) @(negedge clk);
                req_v[0][1] = 1'b1;
                repeat (5) @(negedge clk);
                req_v[0][1] = 1'b0;
            end
        join
        check_quiet(0, 2 * C, "withdraw");
    endtask

    task automatic rand_step(input logic allow_new, input string name);
        int         waited;
        int         win;
        int         j;
        logic [1:0] fresh;
        logic [7:0] b;
        if (req_v[0] == 2'b00 && allow_new) begin
            fresh = 2'($urandom_range(1, 3));
            for (int i = 0; i < 2; i++)
                if (fresh[i]) data_v[0][8*i +: 8] = 8'($urandom);
            req_v[0] = fresh;
        end
        win = -1;
        for (int k = 0; k < 2; k++) begin
            j = (rr_model + k) % 2;
            if (win < 0 && req_v[0][j]) win = j;
        end
        if (win < 0) return;
        wait_gnt(0, 2'(1 << win), name, waited);
        b = data_v[0][8*win +: 8];
        req_v[0][win] = 1'b0;
        rr_model = (win + 1) % 2;
        run_frame(0, b, win, name);
    endtask

    task automatic test_random();
        do_reset();
        for (int it = 0; it < 8; it++) rand_step(1'b1, "random");
        rand_step(1'b0, "random drain");
    endtask

    initial begin
        for (int w = 0; w < 3; w++) begin
            req_v[w]  = 2'b00;
            data_v[w] = 16'h0000;
        end
        test_reset();
        test_single();
        test_alternate();
        test_odd_parity();
        test_no_parity();
        test_reset_midframe();
        test_withdraw_sample();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
